// File: rtl/logic_op_pkg.sv
// Shared types and the reference bitwise operation for the logic_op_pipe slice chain.
package logic_op_pkg;

    localparam int unsigned C_MAX_STAGES = 4;
    localparam int unsigned C_MAX_WIDTH  = 256;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef logic [C_MAX_WIDTH-1:0] word_t;

    // Operands arrive zero-extended to C_MAX_WIDTH; callers keep only their low bits.
    function automatic word_t logic_op(input op_t op, input word_t a, input word_t b);
        word_t r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_slice.sv
// One valid/data register slice; loads when its advance enable is high.
module logic_op_slice
    import logic_op_pkg::*;
#(
    parameter int unsigned G_DW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_adv,
    input  logic            i_vld,
    input  logic [G_DW-1:0] i_data,
    output logic            o_vld,
    output logic [G_DW-1:0] o_data
);

    logic            r_vld;
    logic [G_DW-1:0] r_data;

    // Data only moves with a valid beat so a bubble never overwrites a held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_adv) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/logic_op_pipe.sv
// Pipelined selectable bitwise operator with valid/ready backpressure and a result counter.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int unsigned G_WIDTH  = 8,
    parameter int unsigned G_STAGES = 2,
    parameter int unsigned G_CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  op_t                s_op,
    input  logic [G_WIDTH-1:0] s_a,
    input  logic [G_WIDTH-1:0] s_b,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [G_WIDTH-1:0] m_c,
    output logic               m_zero,
    output logic [G_CNT_W-1:0] cnt
);

    localparam int unsigned C_DW = G_WIDTH + 1;

    if (G_WIDTH < 1 || G_WIDTH > C_MAX_WIDTH) begin : g_bad_width
        $error("logic_op_pipe: G_WIDTH out of range");
    end
    if (G_STAGES < 1 || G_STAGES > C_MAX_STAGES) begin : g_bad_stages
        $error("logic_op_pipe: G_STAGES out of range");
    end
    if (G_CNT_W < 1) begin : g_bad_cnt
        $error("logic_op_pipe: G_CNT_W must be at least 1");
    end

    logic [G_WIDTH-1:0]  w_res;
    logic                w_zero;
    logic [G_STAGES-1:0] w_vld;
    logic [G_STAGES-1:0] w_adv;
    logic [C_DW-1:0]     w_data [G_STAGES];
    logic [G_CNT_W-1:0]  r_cnt;

    assign w_res  = G_WIDTH'(logic_op(s_op, C_MAX_WIDTH'(s_a), C_MAX_WIDTH'(s_b)));
    assign w_zero = ~|w_res;

    for (genvar i = 0; i < G_STAGES; i++) begin : g_stage
        logic            w_in_vld;
        logic [C_DW-1:0] w_in_data;

        if (i == 0) begin : g_head
            assign w_in_vld  = s_valid;
            assign w_in_data = {w_zero, w_res};
        end else begin : g_body
            assign w_in_vld  = w_vld[i-1];
            assign w_in_data = w_data[i-1];
        end

        // Unrolled form of adv[i] = !vld[i] || adv[i+1]: a slice moves unless it and
        // everything downstream is full while the sink stalls.
        assign w_adv[i] = m_ready || !(&w_vld[G_STAGES-1:i]);

        logic_op_slice #(
            .G_DW(C_DW)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .i_adv  (w_adv[i]),
            .i_vld  (w_in_vld),
            .i_data (w_in_data),
            .o_vld  (w_vld[i]),
            .o_data (w_data[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (m_valid && m_ready) begin
            r_cnt <= r_cnt + G_CNT_W'(1);
        end
    end

    assign s_ready = w_adv[0];
    assign m_valid = w_vld[G_STAGES-1];
    assign m_c     = w_data[G_STAGES-1][G_WIDTH-1:0];
    assign m_zero  = w_data[G_STAGES-1][G_WIDTH];
    assign cnt     = r_cnt;

    a_hold_valid : assert property (@(posedge clk) disable iff (rst)
        m_valid && !m_ready |=> m_valid);
    a_hold_data : assert property (@(posedge clk) disable iff (rst)
        m_valid && !m_ready |=> $stable(m_c) && $stable(m_zero));

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Parametrised, pipelined successor to the combinational bitwise AND block.
- Applies a run-time selectable bitwise operation (AND/OR/XOR/NAND) to two G_WIDTH-bit operands.
- Carries the result through G_STAGES register slices with a valid/ready handshake and backpressure.
- Sits between a streaming source and sink; also keeps a completed-transaction counter for bench and debug visibility.

Parameters:
- G_WIDTH, 8, operand/result width in bits; legal range 1..256.
- G_STAGES, 2, number of register slices; legal range 1..4.
- G_CNT_W, 32, width of the transaction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input transaction valid.
- s_ready  out  1  block can accept an input this cycle.
- s_op  in  2  operation select (logic_op_pkg::op_t).
- s_a  in  G_WIDTH  operand A.
- s_b  in  G_WIDTH  operand B.
- m_valid  out  1  output result valid.
- m_ready  in  1  sink accepts the result.
- m_c  out  G_WIDTH  result.
- m_zero  out  1  high when m_c is all zeros; qualified by m_valid.
- cnt  out  G_CNT_W  count of accepted outputs (m_valid && m_ready).

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - every stage valid = 0, every data register = 0, cnt = 0.
  - Therefore m_valid = 0, m_c = 0, m_zero = 0 during and after reset.
  - s_ready = 1 once rst is low.
- Operation encoding: 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NAND.
  - Computed combinationally from s_a/s_b/s_op ahead of stage 0 and registered on acceptance.
  - m_zero is computed in the same cycle and carried with the data.
- Input acceptance: when s_valid && s_ready on a rising edge.
  - s_op/s_a/s_b are sampled only on acceptance; no other cycle matters.
- Stage advance:
  - adv[i] = !vld[i] || adv[i+1] for i < G_STAGES-1.
  - adv[last] = !vld[last] || m_ready.
  - s_ready = adv[0].
  - This makes the pipe bubble-collapsing: an empty slice fills even while downstream is stalled.
- Outputs and timing:
  - m_valid = vld[last]; m_c and m_zero come from the last slice.
  - Latency is G_STAGES cycles from acceptance to m_valid with m_ready held high.
  - Throughput is 1 result/cycle.
- Stall: while m_valid && !m_ready, m_c/m_zero/m_valid hold stable.
  - Up to G_STAGES transactions may be buffered.
  - s_ready drops only when all slices are full and m_ready = 0.
- Simultaneous accept and drain on a full pipe:
  - allowed when m_ready = 1 (s_ready = 1 via the combinational chain).
  - No combinational path from s_valid to s_ready.
  - The m_ready-to-s_ready path is permitted.
- Counter:
  - cnt increments by 1 on each m_valid && m_ready edge.
  - Wraps from 2^G_CNT_W-1 to 0 with no flag.
- Ordering: results exit strictly in acceptance order; no drops, no duplicates.
- Reset mid-operation: all in-flight transactions are discarded, cnt clears, and m_valid falls asynchronously with rst.
- Validity rules: m_valid never depends on m_ready. Once asserted, m_valid stays asserted until the handshake completes.

Decomposition:
- Package logic_op_pkg holds:
  - op_t enum {OP_AND, OP_OR, OP_XOR, OP_NAND} (2-bit);
  - function logic_op(op_t, a, b) returning the result (width-generic via a parameterised class or a max-width vector, sliced);
  - localparam C_MAX_STAGES = 4.
- Sub-module logic_op_slice: one valid/data register slice with G_WIDTH+1 data bits (result + zero flag) and the adv logic.
  - Instantiated G_STAGES times in a generate loop.
  - Top level holds the op function call, the counter and the port mapping.

Test Plan:
1. Reset then stream, G_WIDTH=8, G_STAGES=2, m_ready=1.
   - Stimulus: accept (OP_AND, 0xF0, 0x3C), (OP_OR, 0xF0, 0x3C), (OP_XOR, 0xF0, 0x3C), (OP_NAND, 0xF0, 0x3C) on consecutive cycles.
   - Required: m_c = 0x30, 0xFC, 0xCC, 0xCF on cycles 2..5 after the first accept; m_zero = 0 throughout; cnt = 4.
2. Zero flag.
   - Stimulus: OP_AND 0xAA, 0x55.
   - Required: m_c = 0x00, m_zero = 1, valid 2 cycles after acceptance.
3. Backpressure.
   - Stimulus: m_ready = 0 and s_valid = 1 continuously.
   - Required: exactly 2 accepts, then s_ready = 0; m_c holds the first result stable.
   - Then raise m_ready: results drain in order, one per cycle, with no loss.
4. Random soak.
   - Stimulus: 1000 random ops/operands, random s_valid and m_ready (50%); scoreboard against the reference function.
   - Required: zero mismatches and cnt = 1000.
5. Counter wrap with G_CNT_W = 4.
   - Stimulus: 17 transactions.
   - Required: cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
6. Reset mid-stream.
   - Stimulus: assert rst with 2 results buffered and m_ready = 0.
   - Required: m_valid = 0 immediately (asynchronous) and cnt = 0.
   - After release, the first new accept (OP_OR, 0x01, 0x02) yields m_c = 0x03 with no stale data.
